// File: rtl/branch_resolve.sv
// branch_resolve: MEM-stage branch/jump resolution driving fetch redirect, flush and link writeback
module branch_resolve #(
    parameter int XLEN           = 32,
    parameter int ALIGN_MASK_BIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_ex,
    input  logic            is_branch_ex,
    input  logic            is_jal_ex,
    input  logic            is_jalr_ex,
    input  logic [2:0]      funct3_ex,
    input  logic [XLEN-1:0] rs1_ex,
    input  logic [XLEN-1:0] rs2_ex,
    input  logic [XLEN-1:0] imm_ex,
    input  logic [XLEN-1:0] PC_ex,
    input  logic            stall_mem,
    output logic            branch_mem_if,
    output logic [XLEN-1:0] PC_branch_mem_if,
    output logic            flush_mem,
    output logic [XLEN-1:0] link_mem_wb,
    output logic            link_valid_mem_wb,
    output logic            misalign_mem
);
    logic            valid_q, is_branch_q, is_jal_q, is_jalr_q, fired;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] rs1_q, rs2_q, imm_q, pc_q;
    logic            cond, taken, misaligned, jump;
    logic [XLEN-1:0] sum, target;

    // Resolve condition, target and alignment from the held slot; jalr wins over jal over branch
    always_comb begin
        cond = funct3_q == 3'b000 ? rs1_q == rs2_q :
               funct3_q == 3'b001 ? rs1_q != rs2_q :
               funct3_q == 3'b100 ? $signed(rs1_q) <  $signed(rs2_q) :
               funct3_q == 3'b101 ? $signed(rs1_q) >= $signed(rs2_q) :
               funct3_q == 3'b110 ? rs1_q <  rs2_q :
               funct3_q == 3'b111 ? rs1_q >= rs2_q : 1'b0;
        jump = is_jal_q | is_jalr_q;
        sum = is_jalr_q ? rs1_q + imm_q : pc_q + imm_q;
        target = is_jalr_q ? {sum[XLEN-1:1], 1'b0} : sum;
        taken = valid_q & (jump | (is_branch_q & cond));
        misaligned = taken & target[ALIGN_MASK_BIT];
    end

    assign branch_mem_if     = taken & ~misaligned & ~fired;
    assign flush_mem         = branch_mem_if;
    assign PC_branch_mem_if  = branch_mem_if ? target : '0;
    assign misalign_mem      = misaligned & ~fired;
    assign link_mem_wb       = valid_q ? pc_q + XLEN'(4) : '0;
    assign link_valid_mem_wb = valid_q & jump & ~misaligned;

    // A stalled slot holds and remembers it already fired; a redirect squashes the wrong-path EX op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {valid_q, is_branch_q, is_jal_q, is_jalr_q, fired} <= '0;
            funct3_q <= '0;
            {rs1_q, rs2_q, imm_q, pc_q} <= '0;
        end else if (stall_mem) begin
            fired <= fired | branch_mem_if | misalign_mem;
        end else if (branch_mem_if) begin
            {valid_q, is_branch_q, is_jal_q, is_jalr_q, fired} <= '0;
        end else begin
            valid_q     <= valid_ex;
            is_branch_q <= is_branch_ex;
            is_jal_q    <= is_jal_ex;
            is_jalr_q   <= is_jalr_ex;
            funct3_q    <= funct3_ex;
            rs1_q       <= rs1_ex;
            rs2_q       <= rs2_ex;
            imm_q       <= imm_ex;
            pc_q        <= PC_ex;
            fired       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and random checks of branch_resolve against a behavioural slot model
module tb_branch_resolve;
    logic        clk = 0, rst = 1;
    logic        valid_ex = 0, is_branch_ex = 0, is_jal_ex = 0, is_jalr_ex = 0, stall_mem = 0;
    logic [2:0]  funct3_ex = 0;
    logic [31:0] rs1_ex = 0, rs2_ex = 0, imm_ex = 0, PC_ex = 0;
    logic        branch_mem_if, flush_mem, link_valid_mem_wb, misalign_mem;
    logic [31:0] PC_branch_mem_if, link_mem_wb;
    logic [67:0] dut_vec, e;
    int          vectors = 0, errors = 0;

    typedef struct packed {
        bit v, b, j, jr;
        bit [2:0] f;
        bit [31:0] rs1, rs2, imm, pc;
        bit fired;
    } slot_t;
    slot_t s = '0;

    branch_resolve dut (
        .clk(clk), .rst(rst), .valid_ex(valid_ex), .is_branch_ex(is_branch_ex),
        .is_jal_ex(is_jal_ex), .is_jalr_ex(is_jalr_ex), .funct3_ex(funct3_ex),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .imm_ex(imm_ex), .PC_ex(PC_ex),
        .stall_mem(stall_mem), .branch_mem_if(branch_mem_if),
        .PC_branch_mem_if(PC_branch_mem_if), .flush_mem(flush_mem),
        .link_mem_wb(link_mem_wb), .link_valid_mem_wb(link_valid_mem_wb),
        .misalign_mem(misalign_mem)
    );

    always #5 clk = ~clk;

    assign dut_vec = {branch_mem_if, PC_branch_mem_if, flush_mem, link_mem_wb, link_valid_mem_wb, misalign_mem};

    function automatic bit cond(bit [2:0] f, bit [31:0] a, bit [31:0] b);
        int sa = a, sb = b;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    // Expected {branch, target, flush, link, link_valid, misalign} for a slot
    function automatic logic [67:0] exp_vec(slot_t x);
        bit [31:0] t;
        bit tk, mis, br, jmp;
        jmp = x.j | x.jr;
        t = x.jr ? (x.rs1 + x.imm) & 32'hFFFF_FFFE : x.pc + x.imm;
        tk = x.v && (jmp || (x.b && cond(x.f, x.rs1, x.rs2)));
        mis = tk && t[1];
        br = tk && !mis && !x.fired;
        return {br, br ? t : 32'd0, br, x.v ? x.pc + 32'd4 : 32'd0, x.v && jmp && !mis, mis && !x.fired};
    endfunction

    task automatic set_ex(bit v, bit b, bit j, bit jr, bit [2:0] f, bit [31:0] a, bit [31:0] c, bit [31:0] i, bit [31:0] p);
        {valid_ex, is_branch_ex, is_jal_ex, is_jalr_ex, funct3_ex} = {v, b, j, jr, f};
        {rs1_ex, rs2_ex, imm_ex, PC_ex} = {a, c, i, p};
    endtask

    task automatic tick();
        logic [67:0] x;
        x = exp_vec(s);
        if (stall_mem) s.fired = s.fired | x[67] | x[0];
        else if (x[67]) s = '0;
        else s = '{valid_ex, is_branch_ex, is_jal_ex, is_jalr_ex, funct3_ex, rs1_ex, rs2_ex, imm_ex, PC_ex, 1'b0};
        @(posedge clk);
        #1;
        e = exp_vec(s);
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (dut_vec !== 68'd0) begin errors++; $display("FAIL reset_hold got=%h exp=%h", dut_vec, 68'd0); end
        @(negedge clk) rst = 0;
        set_ex(1, 0, 1, 0, 0, 0, 0, 32'h40, 32'h100);
        tick();
        vectors++;
        if (dut_vec !== e || branch_mem_if !== 1'b1) begin errors++; $display("FAIL reset_pre_jal got=%h exp=%h", dut_vec, e); end
        stall_mem = 1;
        @(negedge clk);
        #2 rst = 1;
        s = '0;
        #1;
        vectors++;
        if (dut_vec !== 68'd0) begin errors++; $display("FAIL reset_async got=%h exp=%h", dut_vec, 68'd0); end
        @(negedge clk) rst = 0;
        stall_mem = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_beq();
        set_ex(1, 1, 0, 0, 3'd0, 32'h5, 32'h5, 32'h20, 32'h100);
        tick();
        vectors++;
        if (dut_vec !== e || PC_branch_mem_if !== 32'h120 || flush_mem !== 1'b1) begin errors++; $display("FAIL beq_taken got=%h exp=%h", dut_vec, e); end
        set_ex(1, 0, 1, 0, 0, 0, 0, 32'h80, 32'h104);
        tick();
        vectors++;
        if (dut_vec !== e || dut_vec !== 68'd0) begin errors++; $display("FAIL beq_squash got=%h exp=%h", dut_vec, e); end
    endtask

    task automatic test_blt();
        set_ex(1, 1, 0, 0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h200);
        tick();
        vectors++;
        if (dut_vec !== e || branch_mem_if !== 1'b1) begin errors++; $display("FAIL blt_taken got=%h exp=%h", dut_vec, e); end
        set_ex(1, 1, 0, 0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h10, 32'h300);
        tick();
        tick();
        vectors++;
        if (dut_vec !== e || branch_mem_if !== 1'b0) begin errors++; $display("FAIL bltu_not_taken got=%h exp=%h", dut_vec, e); end
    endtask

    task automatic test_jalr();
        set_ex(1, 0, 0, 1, 0, 32'h203, 0, 32'h4, 32'h40);
        tick();
        vectors++;
        if (dut_vec !== e || misalign_mem !== 1'b1 || branch_mem_if !== 1'b0) begin errors++; $display("FAIL jalr_misalign got=%h exp=%h", dut_vec, e); end
        set_ex(1, 0, 0, 1, 0, 32'h201, 0, 32'h4, 32'h40);
        tick();
        vectors++;
        if (dut_vec !== e || PC_branch_mem_if !== 32'h204 || link_mem_wb !== 32'h44 || link_valid_mem_wb !== 1'b1) begin errors++; $display("FAIL jalr_aligned got=%h exp=%h", dut_vec, e); end
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_stall_jal();
        set_ex(1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h500);
        tick();
        stall_mem = 1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dut_vec !== e || link_valid_mem_wb !== 1'b1 || branch_mem_if !== (i == 0)) begin errors++; $display("FAIL stall_jal_c%0d got=%h exp=%h", i, dut_vec, e); end
            if (i < 2) tick();
        end
        tick();
        stall_mem = 0;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_wrap();
        set_ex(1, 0, 1, 0, 0, 0, 0, 32'h8, 32'hFFFF_FFFC);
        tick();
        vectors++;
        if (dut_vec !== e || PC_branch_mem_if !== 32'h4 || link_mem_wb !== 32'h0) begin errors++; $display("FAIL jal_wrap got=%h exp=%h", dut_vec, e); end
        set_ex(1, 1, 0, 0, 3'd2, 32'h7, 32'h7, 32'h8, 32'h600);
        tick();
        tick();
        vectors++;
        if (dut_vec !== e || branch_mem_if !== 1'b0) begin errors++; $display("FAIL funct3_010 got=%h exp=%h", dut_vec, e); end
    endtask

    task automatic test_random();
        bit [31:0] a, c, i, p;
        bit [2:0] t;
        for (int n = 0; n < 400; n++) begin
            a = $urandom; c = ($urandom_range(0, 3) == 0) ? a : $urandom;
            i = $urandom; p = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 0) i = i & 32'h0000_0FFC;
            if ($urandom_range(0, 1) == 0) i = {i[31:2], 2'($urandom_range(0, 3))};
            t = 3'($urandom_range(0, 7));
            set_ex($urandom_range(0, 9) != 0, t[0], t[1], t[2], 3'($urandom_range(0, 7)), a, c, i, p);
            stall_mem = $urandom_range(0, 9) < 3;
            tick();
            vectors++;
            if (dut_vec !== e) begin errors++; $display("FAIL random_%0d got=%h exp=%h", n, dut_vec, e); end
        end
        stall_mem = 0;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt();
        test_jalr();
        test_stall_jal();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
